// File: rtl/bus_arbiter_lv1_lv2.sv
// Per-core owner arbiter for the shared lv1<->lv2 bus: grants il, dl or snoop one at a time, non-preemptive.
// Define BUS_ARB_LV1_LV2_TIMEOUT_EN to force release of an owner that holds the bus beyond MAX_HOLD cycles.
module bus_arbiter_lv1_lv2 #(
  parameter int HOLD_CNT_WID   = 8,
  parameter int MAX_HOLD       = 200,
  parameter bit SNOOP_PRIORITY = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bus_lv1_lv2_req_proc_il,
  input  logic bus_lv1_lv2_req_proc_dl,
  input  logic bus_lv1_lv2_req_snoop,
  output logic bus_lv1_lv2_gnt_proc_il,
  output logic bus_lv1_lv2_gnt_proc_dl,
  output logic bus_lv1_lv2_gnt_snoop,
  output logic bus_lv1_lv2_busy,
  output logic bus_lv1_lv2_timeout_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN_IL = 2'd1, OWN_DL = 2'd2, OWN_SNP = 2'd3} state_e;
  typedef enum logic [1:0] {SLOT_IL = 2'd0, SLOT_DL = 2'd1, SLOT_SNP = 2'd2} slot_e;

  if (MAX_HOLD >= (1 << HOLD_CNT_WID)) begin : g_bad_max_hold
    $error("MAX_HOLD must fit in the hold counter");
  end

  // With snoop priority the pointer only rotates il/dl; a snoop win leaves it where it was.
  function automatic slot_e slot_after(input slot_e s, input slot_e cur);
    slot_e nxt;
    nxt = cur;
    if (SNOOP_PRIORITY) begin
      if (s == SLOT_IL)      nxt = SLOT_DL;
      else if (s == SLOT_DL) nxt = SLOT_IL;
    end else begin
      unique case (s)
        SLOT_IL: nxt = SLOT_DL;
        SLOT_DL: nxt = SLOT_SNP;
        default: nxt = SLOT_IL;
      endcase
    end
    return nxt;
  endfunction

  state_e                  state_q, state_d;
  slot_e                   rr_ptr_q, rr_ptr_d;
  logic [HOLD_CNT_WID-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]              gnt_q, gnt_d;
  logic                    busy_q, busy_d;
  slot_e                   win_slot;
  logic                    win_valid;
  logic                    owner_req;

  wire req_il  = bus_lv1_lv2_req_proc_il;
  wire req_dl  = bus_lv1_lv2_req_proc_dl;
  wire req_snp = bus_lv1_lv2_req_snoop;

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    win_valid = 1'b1;
    win_slot  = SLOT_IL;
    if (SNOOP_PRIORITY) begin
      if (req_snp)               win_slot = SLOT_SNP;
      else if (req_il && req_dl) win_slot = rr_ptr_q;
      else if (req_il)           win_slot = SLOT_IL;
      else if (req_dl)           win_slot = SLOT_DL;
      else                       win_valid = 1'b0;
    end else begin
      unique case (rr_ptr_q)
        SLOT_IL: begin
          if (req_il)       win_slot = SLOT_IL;
          else if (req_dl)  win_slot = SLOT_DL;
          else if (req_snp) win_slot = SLOT_SNP;
          else              win_valid = 1'b0;
        end
        SLOT_DL: begin
          if (req_dl)       win_slot = SLOT_DL;
          else if (req_snp) win_slot = SLOT_SNP;
          else if (req_il)  win_slot = SLOT_IL;
          else              win_valid = 1'b0;
        end
        default: begin
          if (req_snp)      win_slot = SLOT_SNP;
          else if (req_il)  win_slot = SLOT_IL;
          else if (req_dl)  win_slot = SLOT_DL;
          else              win_valid = 1'b0;
        end
      endcase
    end
  end

`ifdef BUS_ARB_LV1_LV2_TIMEOUT_EN
  localparam logic [HOLD_CNT_WID-1:0] MAX_HOLD_C = HOLD_CNT_WID'(MAX_HOLD);
  logic terr_q, terr_d;
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
`ifdef BUS_ARB_LV1_LV2_TIMEOUT_EN
    terr_d     = 1'b0;
`endif
    owner_req  = (state_q == OWN_IL  && req_il) ||
                 (state_q == OWN_DL  && req_dl) ||
                 (state_q == OWN_SNP && req_snp);
    if (state_q == IDLE) begin
      if (win_valid) begin
        state_d    = state_e'(win_slot + 2'd1);
        rr_ptr_d   = slot_after(win_slot, rr_ptr_q);
        hold_cnt_d = '0;
      end
    end else begin
      hold_cnt_d = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + HOLD_CNT_WID'(1);
      if (!owner_req) begin
        state_d = IDLE;
`ifdef BUS_ARB_LV1_LV2_TIMEOUT_EN
      end else if (hold_cnt_q == MAX_HOLD_C) begin
        state_d  = IDLE;
        terr_d   = 1'b1;
        rr_ptr_d = slot_after(slot_e'(state_q - 2'd1), rr_ptr_q);
`endif
      end
    end
    gnt_d  = {state_d == OWN_SNP, state_d == OWN_DL, state_d == OWN_IL};
    busy_d = |gnt_d;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= SLOT_IL;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
`ifdef BUS_ARB_LV1_LV2_TIMEOUT_EN
      terr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
`ifdef BUS_ARB_LV1_LV2_TIMEOUT_EN
      terr_q     <= terr_d;
`endif
    end
  end

  assign bus_lv1_lv2_gnt_proc_il = gnt_q[0];
  assign bus_lv1_lv2_gnt_proc_dl = gnt_q[1];
  assign bus_lv1_lv2_gnt_snoop   = gnt_q[2];
  assign bus_lv1_lv2_busy        = busy_q;
`ifdef BUS_ARB_LV1_LV2_TIMEOUT_EN
  assign bus_lv1_lv2_timeout_err = terr_q;
`else
  assign bus_lv1_lv2_timeout_err = 1'b0;
`endif

endmodule
